// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave):
// a valid/ready request channel and an in-order, non-backpressured response channel.
interface if_stage_if #(
  parameter int BUS_WIDTH   = 64,
  parameter int INSTR_WIDTH = 32
) ();
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [BUS_WIDTH-1:0]   imem_req_addr;
  logic                   imem_resp_valid;
  logic [INSTR_WIDTH-1:0] imem_resp_instr;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_instr
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_instr
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order fetches, buffers
// returned instructions for decode and drops wrong-path responses after a redirect.
module if_stage #(
  parameter int                   BUS_WIDTH   = 64,
  parameter int                   INSTR_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC    = '0,
  parameter int                   DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  if_stage_if.master             imem,
  input  logic                   stall,
  input  logic                   imm_pc,
  input  logic [BUS_WIDTH-1:0]   next_imm_pc,
  output logic [BUS_WIDTH-1:0]   pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  logic [BUS_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0]        inflight_reg, inflight_next;
  logic [CW-1:0]        discard_reg, discard_next;
  // Ring pointers carry a wrap bit so that full and empty are distinguishable.
  logic [CW-1:0]        head_reg, head_next;
  logic [CW-1:0]        fill_reg, fill_next;
  logic [CW-1:0]        tail_reg, tail_next;
  logic                 started_reg;

  logic [BUS_WIDTH-1:0]   pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

  logic [CW-1:0] alloc_cnt, filled_cnt;
  logic          req_fire, resp_fire, redirect;
  logic          push_en, fill_en, pop_en;
  logic [PW-1:0] head_idx, fill_idx, tail_idx;

  assign alloc_cnt  = tail_reg - head_reg;
  assign filled_cnt = fill_reg - head_reg;
  assign head_idx   = head_reg[PW-1:0];
  assign fill_idx   = fill_reg[PW-1:0];
  assign tail_idx   = tail_reg[PW-1:0];

  // Allocated entries equal live requests plus filled entries, so capacity is
  // reserved at issue and a response always has a slot.
  assign imem.imem_req_valid = started_reg && (inflight_reg < CW'(DEPTH))
                               && (alloc_cnt < CW'(DEPTH));
  assign imem.imem_req_addr  = fetch_pc_reg;

  assign req_fire  = imem.imem_req_valid & imem.imem_req_ready;
  assign resp_fire = imem.imem_resp_valid;
  assign redirect  = imm_pc & instr_valid & ~stall;

  assign push_en = req_fire & ~redirect;
  assign fill_en = resp_fire & (discard_reg == '0) & ~redirect;
  assign pop_en  = instr_valid & ~stall & ~redirect;

  assign instr_valid = (filled_cnt != '0);
  assign pc          = instr_valid ? pc_mem[head_idx]    : '0;
  assign instr       = instr_valid ? instr_mem[head_idx] : NOP;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    inflight_next = inflight_reg + CW'(req_fire) - CW'(resp_fire);
    discard_next  = discard_reg;
    head_next     = head_reg;
    fill_next     = fill_reg;
    tail_next     = tail_reg;
    if (redirect) begin
      // Every old-stream request still unanswered after this edge is wrong-path.
      fetch_pc_next = next_imm_pc;
      discard_next  = inflight_next;
      head_next     = '0;
      fill_next     = '0;
      tail_next     = '0;
    end else begin
      if (req_fire)
        fetch_pc_next = fetch_pc_reg + BUS_WIDTH'(4);
      if (resp_fire && (discard_reg != '0))
        discard_next = discard_reg - CW'(1);
      if (push_en)
        tail_next = tail_reg + CW'(1);
      if (fill_en)
        fill_next = fill_reg + CW'(1);
      if (pop_en)
        head_next = head_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg <= RESET_PC;
      inflight_reg <= '0;
      discard_reg  <= '0;
      head_reg     <= '0;
      fill_reg     <= '0;
      tail_reg     <= '0;
      started_reg  <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      inflight_reg <= inflight_next;
      discard_reg  <= discard_next;
      head_reg     <= head_next;
      fill_reg     <= fill_next;
      tail_reg     <= tail_next;
      started_reg  <= 1'b1;
    end
  end

  // Entry payloads need no reset: an entry is only read once its pointers mark it filled.
  always_ff @(posedge clk) begin
    if (push_en)
      pc_mem[tail_idx] <= fetch_pc_reg;
    if (fill_en)
      instr_mem[fill_idx] <= imem.imem_resp_instr;
  end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order memory model with random latency/ready, a decode
// driver holding a program-order PC model, and a monitor that scores every pop.
module tb_if_stage;
  localparam int          BW    = 64;
  localparam int          IW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [63:0] RPC   = 64'h1000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_stage_if #(.BUS_WIDTH(BW), .INSTR_WIDTH(IW)) imem ();

  logic          stall = 1'b0;
  logic          imm_pc = 1'b0;
  logic [63:0]   next_imm_pc = '0;
  logic [63:0]   pc;
  logic [31:0]   instr;
  logic          instr_valid;

  if_stage #(.BUS_WIDTH(BW), .INSTR_WIDTH(IW), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem.master),
    .stall       (stall),
    .imm_pc      (imm_pc),
    .next_imm_pc (next_imm_pc),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  // Memory image: each word is a fixed function of its address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ 32'hC0DE_0000;
  endfunction

  // Test controls, written only by the main sequence.
  int          ready_mode = 1;   // 0 random, 1 always, 2 held low
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rnd_dec = 1'b0;
  bit          dir_stall = 1'b0;
  int          redir_req = 0;
  logic [63:0] redir_target = '0;

  // Observations, each written by a single process.
  int          cyc = 0;
  int          acc_cnt = 0;
  logic [63:0] last_acc = '0;
  int          redir_done = 0;
  int          consumed = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;
  resp_t       mq[$];
  logic [63:0] exp_q[$];
  logic [63:0] mpc = RPC;

  // Instruction memory: in order, latency lat_min..lat_max cycles.
  initial begin
    imem.imem_req_ready  = 1'b0;
    imem.imem_resp_valid = 1'b0;
    imem.imem_resp_instr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
      end else begin
        if (imem.imem_resp_valid)
          void'(mq.pop_front());
        if (imem.imem_req_valid && imem.imem_req_ready) begin
          mq.push_back('{cyc + int'($urandom_range(lat_max, lat_min)), mem_word(imem.imem_req_addr)});
          acc_cnt++;
          last_acc = imem.imem_req_addr;
          chk("inflight_bound", 64'(mq.size() <= DEPTH), 64'd1);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      imem.imem_req_ready = (ready_mode == 1) ? 1'b1 :
                            (ready_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_instr = mq[0].data;
      end else begin
        imem.imem_resp_valid = 1'b0;
      end
    end
  end

  // Decode driver: program-order model of which PC each pop must carry.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        stall  = 1'b0;
        imm_pc = 1'b0;
        mpc    = RPC;
      end else begin
        stall = rnd_dec ? ($urandom_range(0, 3) == 0) : dir_stall;
        if (redir_done < redir_req) begin
          imm_pc      = 1'b1;
          next_imm_pc = redir_target;
        end else if (rnd_dec && $urandom_range(0, 7) == 0) begin
          imm_pc      = 1'b1;
          next_imm_pc = ($urandom_range(0, 5) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                                    : {32'h0, $urandom & 32'hFFFF_FFFC};
        end else begin
          imm_pc = 1'b0;
        end
        if (instr_valid && !stall) begin
          exp_q.push_back(mpc);
          mpc = imm_pc ? next_imm_pc : mpc + 64'd4;
          if (imm_pc && redir_done < redir_req)
            redir_done++;
        end
      end
    end
  end

  // Monitor: scores every pop against the expected program order.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else if (instr_valid && !stall) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 64'd0, 64'd1);
        end else begin
          e = exp_q.pop_front();
          consumed++;
          $display("pop pc=%h instr=%h", pc, instr);
          chk("pc", pc, e);
          chk("instr", 64'(instr), 64'(mem_word(e)));
        end
      end else if (!instr_valid) begin
        chk("idle_pc", pc, 64'd0);
        chk("idle_instr", 64'(instr), 64'(NOP));
      end
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 64'(imem.imem_req_valid), 64'd0);
    chk({tag, "_instr_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, "_pc"}, pc, 64'd0);
    chk({tag, "_instr"}, 64'(instr), 64'(NOP));
  endtask

  task automatic wait_accept_addr(input string nm, input int snap, input logic [63:0] req);
    int n = 0;
    while (acc_cnt == snap && n < 60) begin
      step(1);
      n++;
    end
    chk({nm, "_seen"}, 64'(acc_cnt != snap), 64'd1);
    chk(nm, last_acc, req);
  endtask

  task automatic redirect_check(input logic [63:0] tgt, input bit hold);
    int n = 0;
    int snap;
    if (hold) begin
      ready_mode = 2;
      dir_stall  = 1'b1;
      step(6);
      dir_stall  = 1'b0;
    end
    redir_target = tgt;
    redir_req++;
    while (redir_done < redir_req && n < 60) begin
      step(1);
      n++;
    end
    chk("redirect_taken", 64'(redir_done == redir_req), 64'd1);
    step(1);
    snap = acc_cnt;
    if (hold) begin
      step(4);
      chk("redir_wait_addr", imem.imem_req_addr, tgt);
      chk("redir_wait_valid", 64'(imem.imem_req_valid), 64'd1);
      ready_mode = 1;
    end
    wait_accept_addr("redir_first_addr", snap, tgt);
  endtask

  initial begin
    int n;
    int snap;
    logic [63:0] hold_pc;

    step(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // First fetch address and request-to-output latency with 1-cycle memory.
    n = 0;
    while (!(imem.imem_req_valid && imem.imem_req_ready) && n < 20) begin
      step(1);
      n++;
    end
    chk("first_req_seen", 64'(n < 20), 64'd1);
    chk("first_addr", imem.imem_req_addr, RPC);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!instr_valid && n < 20);
    chk("first_latency", 64'(n), 64'd2);
    step(20);

    // Stall with the queue full: head held, no new request.
    dir_stall = 1'b1;
    step(5);
    hold_pc = pc;
    chk("stall_full_valid", 64'(instr_valid), 64'd1);
    repeat (5) begin
      step(1);
      chk("stall_no_req", 64'(imem.imem_req_valid), 64'd0);
      chk("stall_hold_pc", pc, hold_pc);
    end
    dir_stall = 1'b0;
    step(10);

    // Redirects with 3-cycle memory, then while a request waits on ready.
    lat_min = 3;
    lat_max = 3;
    step(10);
    redirect_check(64'h2000, 1'b0);
    step(10);
    redirect_check(64'h3000, 1'b1);
    step(10);

    // Asynchronous reset mid-stream.
    lat_min = 2;
    lat_max = 2;
    step(7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step(2);
    snap = acc_cnt;
    rst_n = 1'b1;
    wait_accept_addr("restart_addr", snap, RPC);

    // Randomized traffic: ready, latency, stall and redirects all random.
    lat_min    = 1;
    lat_max    = 4;
    ready_mode = 0;
    rnd_dec    = 1'b1;
    step(1500);
    rnd_dec    = 1'b0;
    ready_mode = 1;
    step(30);
    chk("consumed_enough", 64'(consumed > 150), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
